// File: rtl/sspwm_pkg.sv
// sspwm_pkg: shared sequencer state type and default ramp configuration
package sspwm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  localparam int DEFAULT_DIV = 5681;
  localparam int DEFAULT_STEPS = 89;
  localparam int SECTORS = 6;
endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: clk/rst, clr zeroes count, en counts 0..div-1, step pulses on the last count
module step_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             step
);
  logic [DIV_W-1:0] cnt;
  assign step = en && !clr && cnt == div - 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= step ? '0 : cnt + 1'b1;
endmodule

// File: rtl/theta_sequencer.sv
// theta_sequencer: run/stop theta ramp (start/stop, cfg handshake) -> theta, sector, ticks, wrap, rev_count, busy
module theta_sequencer
  import sspwm_pkg::*;
#(
  parameter int THETA_W       = 10,
  parameter int DIV_W         = 16,
  parameter int DEFAULT_DIV   = sspwm_pkg::DEFAULT_DIV,
  parameter int DEFAULT_STEPS = sspwm_pkg::DEFAULT_STEPS,
  parameter int SECTORS       = sspwm_pkg::SECTORS,
  parameter int REV_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [THETA_W-1:0] cfg_steps,
  output logic [THETA_W-1:0] theta,
  output logic               theta_tick,
  output logic [2:0]         sector,
  output logic               sector_tick,
  output logic               wrap,
  output logic [REV_W-1:0]   rev_count,
  output logic               busy
);
  state_t             state;
  logic [DIV_W-1:0]   div_reg;
  logic [THETA_W-1:0] steps_reg;
  logic [THETA_W:0]   acc;
  logic [THETA_W:0]   acc_n;
  logic               step;
  logic               last;
  logic               acc_hi;
  assign cfg_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign last      = theta == steps_reg - 1'b1;
  assign acc_n     = acc + (THETA_W+1)'(SECTORS);
  assign acc_hi    = acc_n >= {1'b0, steps_reg};
  step_prescaler #(.DIV_W(DIV_W)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .en   (state != IDLE),
    .div  (div_reg),
    .step (step)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      theta       <= '0;
      sector      <= '0;
      acc         <= '0;
      div_reg     <= DIV_W'(DEFAULT_DIV);
      steps_reg   <= THETA_W'(DEFAULT_STEPS);
      rev_count   <= '0;
      theta_tick  <= 1'b0;
      sector_tick <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      theta_tick  <= step;
      sector_tick <= 1'b0;
      wrap        <= 1'b0;
      if (cfg_valid && cfg_ready) begin
        div_reg   <= cfg_div == '0 ? DIV_W'(1) : cfg_div;
        steps_reg <= cfg_steps < THETA_W'(SECTORS) ? THETA_W'(SECTORS) : cfg_steps;
      end
      if (step && last) begin
        theta       <= '0;
        sector      <= '0;
        acc         <= '0;
        wrap        <= 1'b1;
        sector_tick <= 1'b1;
        rev_count   <= rev_count + 1'b1;
      end else if (step) begin
        theta       <= theta + 1'b1;
        acc         <= acc_hi ? acc_n - {1'b0, steps_reg} : acc_n;
        sector      <= acc_hi ? sector + 3'd1 : sector;
        sector_tick <= acc_hi;
      end
      case (state)
        IDLE:     state <= start && !stop ? RUN : IDLE;
        RUN:      state <= stop ? STOPPING : RUN;
        STOPPING: state <= start && !stop ? RUN : (step && last) ? IDLE : STOPPING;
        default:  state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_theta_sequencer.sv
// tb_theta_sequencer: directed and randomized checks of theta_sequencer against a step-level reference model
module tb_theta_sequencer;
  localparam int TW = 10;
  localparam int DW = 16;
  localparam int RW = 8;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [DW-1:0] cfg_div = '0;
  logic [TW-1:0] cfg_steps = '0;
  logic [TW-1:0] theta;
  logic          theta_tick;
  logic [2:0]    sector;
  logic          sector_tick;
  logic          wrap;
  logic [RW-1:0] rev_count;
  logic          busy;
  int            checks = 0;
  int            errors = 0;
  int            m_div = 5681;
  int            m_steps = 89;
  int            m_theta = 0;
  int            m_sector = 0;
  logic [RW-1:0] m_rev = '0;
  always #5 clk = ~clk;
  theta_sequencer #(.REV_W(RW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_div     (cfg_div),
    .cfg_steps   (cfg_steps),
    .theta       (theta),
    .theta_tick  (theta_tick),
    .sector      (sector),
    .sector_tick (sector_tick),
    .wrap        (wrap),
    .rev_count   (rev_count),
    .busy        (busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic reset_model;
    m_div = 5681;
    m_steps = 89;
    m_theta = 0;
    m_sector = 0;
    m_rev = '0;
  endtask
  // Waits for the next theta step and compares it with the arithmetic model:
  // theta = n mod steps, sector = floor(6*theta/steps), gap = div clocks.
  task automatic step_once(input bit ps, input bit pp);
    int  c;
    int  es;
    bit  found;
    c = 0;
    found = 1'b0;
    start = ps;
    stop = pp;
    while (!found && c < m_div + 2) begin
      tick;
      c++;
      start = 1'b0;
      stop = 1'b0;
      found = theta_tick;
    end
    chk("step_gap", found ? c : -1, m_div);
    m_theta = (m_theta + 1) % m_steps;
    if (m_theta == 0) m_rev++;
    es = m_theta * 6 / m_steps;
    chk("theta", 32'(theta), m_theta);
    chk("sector", 32'(sector), es);
    chk("sector_tick", 32'(sector_tick), 32'(es != m_sector));
    chk("wrap", 32'(wrap), 32'(m_theta == 0));
    chk("rev_count", 32'(rev_count), 32'(m_rev));
    m_sector = es;
  endtask
  task automatic start_run;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_run", 32'(busy), 1);
  endtask
  task automatic load_cfg(input int d, input int s);
    cfg_valid = 1'b1;
    cfg_div = DW'(d);
    cfg_steps = TW'(s);
    chk("cfg_ready_idle", 32'(cfg_ready), 1);
    tick;
    cfg_valid = 1'b0;
    m_div = d == 0 ? 1 : d;
    m_steps = s < 6 ? 6 : s;
  endtask
  task automatic stop_run;
    step_once(1'b0, 1'b1);
    do step_once(1'b0, 1'b0); while (m_theta != 0);
    chk("busy_after_stop", 32'(busy), 0);
    chk("theta_after_stop", 32'(theta), 0);
    chk("sector_after_stop", 32'(sector), 0);
  endtask
  task automatic quiet(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      tick;
      seen += int'(theta_tick);
    end
    chk(tag, seen, 0);
  endtask
  initial begin
    int n;
    repeat (2) tick;
    chk("rst_theta", 32'(theta), 0);
    chk("rst_sector", 32'(sector), 0);
    chk("rst_rev", 32'(rev_count), 0);
    chk("rst_ticks", {29'd0, theta_tick, sector_tick, wrap}, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    rst = 1'b0;
    tick;
    load_cfg(1, 89);
    start_run;
    repeat (89 + 40) step_once(1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrun_rst_theta", 32'(theta), 0);
    chk("midrun_rst_sector", 32'(sector), 0);
    chk("midrun_rst_rev", 32'(rev_count), 0);
    chk("midrun_rst_tick", 32'(theta_tick), 0);
    chk("midrun_rst_busy", 32'(busy), 0);
    chk("midrun_rst_ready", 32'(cfg_ready), 1);
    tick;
    rst = 1'b0;
    reset_model;
    start_run;
    repeat (2) step_once(1'b0, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    reset_model;
    load_cfg(4, 12);
    start_run;
    repeat (12 + 5) step_once(1'b0, 1'b0);
    stop_run;
    quiet("idle_no_tick", 8);
    start_run;
    repeat (3) step_once(1'b0, 1'b0);
    step_once(1'b0, 1'b1);
    step_once(1'b1, 1'b0);
    repeat (m_steps - 5) step_once(1'b0, 1'b0);
    chk("busy_after_cancel", 32'(busy), 1);
    stop_run;
    start_run;
    cfg_valid = 1'b1;
    cfg_div = 16'd2;
    cfg_steps = 10'd8;
    #1;
    chk("cfg_ready_run", 32'(cfg_ready), 0);
    repeat (3) step_once(1'b0, 1'b0);
    stop_run;
    chk("cfg_ready_back", 32'(cfg_ready), 1);
    tick;
    cfg_valid = 1'b0;
    m_div = 2;
    m_steps = 8;
    start_run;
    repeat (10) step_once(1'b0, 1'b0);
    stop_run;
    start = 1'b1;
    stop = 1'b1;
    tick;
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_idle", 32'(busy), 0);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("stop_alone_idle", 32'(busy), 0);
    quiet("idle_quiet", 6);
    repeat (3) begin
      load_cfg(int'($urandom_range(0, 5)), int'($urandom_range(3, 40)));
      start_run;
      n = int'($urandom_range(1, 2 * m_steps));
      repeat (n) step_once(1'b0, 1'b0);
      stop_run;
    end
    load_cfg(0, 3);
    start_run;
    n = (256 - int'(m_rev) + 1) * 6;
    repeat (n) step_once(1'b0, 1'b0);
    stop_run;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/theta_sequencer.md
Name: theta_sequencer

Overview:
Run/stop controller for the SSPWM angle datapath. It owns the theta ramp and sequences it from a programmable clock prescaler. It derives the six-sector index and revolution count that downstream switching-pattern logic consumes. Configuration (step divider, steps per revolution) is loaded through a valid/ready handshake while idle. A requested stop completes cleanly on a revolution boundary.

Parameters:
THETA_W, 10, width of theta and step-count fields
DIV_W, 16, width of prescaler divider
DEFAULT_DIV, 5681, clocks per theta step after reset
DEFAULT_STEPS, 89, theta steps per revolution after reset (theta range 0..STEPS-1)
SECTORS, 6, sectors per revolution
REV_W, 16, revolution counter width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  level; request RUN
stop  in  1  level; request stop at next wrap
cfg_valid  in  1  config offer
cfg_ready  out  1  config accepted when high with cfg_valid
cfg_div  in  DIV_W  clocks per step
cfg_steps  in  THETA_W  steps per revolution
theta  out  THETA_W  current angle index
theta_tick  out  1  one-cycle pulse coincident with each theta update
sector  out  3  sector index 0..SECTORS-1
sector_tick  out  1  one-cycle pulse when sector changes (including wrap)
wrap  out  1  one-cycle pulse when theta returns to 0
rev_count  out  REV_W  completed revolutions, wraps modulo 2^REV_W
busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate): state IDLE, theta 0, sector 0, accumulator 0, prescaler 0, div_reg DEFAULT_DIV, steps_reg DEFAULT_STEPS, rev_count 0, all ticks 0, busy 0.
- cfg_ready = (state == IDLE), combinational from state.
- A handshake loads div_reg and steps_reg on the same edge. The new values apply from the next cycle.
- cfg_div = 0 loads as 1. cfg_steps < SECTORS loads as SECTORS.
- States are IDLE, RUN, STOPPING.
  - IDLE: start & !stop -> RUN, with prescaler cleared. start & stop -> stay IDLE (stop wins). stop alone is ignored.
  - RUN: stop -> STOPPING. start is ignored.
  - STOPPING: start & !stop -> RUN (cancels stop; theta continues uninterrupted). On the wrap step -> IDLE.
- Prescaler counts 0..div_reg-1 in RUN and STOPPING. At div_reg-1 it returns to 0 and a step occurs. The step period is exactly div_reg clocks. The first step occurs div_reg clocks after entering RUN from IDLE.
- On each step, all outputs are registered in the same edge:
  - theta_tick = 1.
  - If theta == steps_reg-1: theta 0, sector 0, accumulator 0, wrap 1, sector_tick 1, rev_count + 1.
  - Else: theta + 1. Let acc_n = acc + SECTORS.
    - If acc_n >= steps_reg: acc = acc_n - steps_reg, sector + 1, sector_tick 1.
    - Else: acc = acc_n.
- Sector k therefore begins at theta = ceil(k*steps_reg/SECTORS). For 89 steps this gives boundaries at 15, 30, 45, 60, 75.
- Accumulator width is THETA_W+1. No overflow is possible because acc < steps_reg.
- Entering IDLE from STOPPING leaves theta 0 and sector 0. rev_count is held, not cleared.
- theta, sector and rev_count hold their values whenever no step occurs.

Decomposition:
- Shared package sspwm_pkg holds the state enum (IDLE, RUN, STOPPING), DEFAULT_DIV, DEFAULT_STEPS and SECTORS.
- One sub-module, step_prescaler, covers the divider counter with clear and enable, and emits a step pulse. Everything else stays in theta_sequencer.

Test Plan:
- Reset defaults: assert rst mid-run with theta = 40 -> theta, sector, rev_count and ticks read 0 immediately; busy 0, cfg_ready 1. After release, start with no config load -> theta_tick period 5681 clocks, wrap after 89 steps.
- Config and timing: load div=4, steps=12, then start. First theta_tick 4 clocks after RUN entry, then every 4 clocks. Sector increments at theta 2, 4, 6, 8, 10. wrap and sector_tick occur together at the 12th step (theta 11 -> 0). rev_count = 1.
- Stop on boundary: div=4, steps=12, assert stop at theta = 5 -> stepping continues to wrap, then busy 0, theta 0, sector 0. Cancel case: start during STOPPING -> stays busy, no theta gap.
- Handshake gating: cfg_valid held during RUN -> cfg_ready 0, no load. Load happens on the first IDLE cycle.
- Config clamping: cfg_div=0 -> step every clock. cfg_steps=3 -> steps_reg=6, and sector changes on every step.
- Simultaneous start & stop in IDLE -> remains IDLE. rev_count at 2^REV_W-1 plus one wrap -> reads 0.
